// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle of N lanes. The arbiter uses an N-lane instance as its
// input side and a 1-lane instance as its output side.
interface axis_rr_arbiter_if #(
    parameter int N     = 1,
    parameter int DW    = 512,
    parameter int IW    = 2,
    parameter int DESTW = 2
);
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N-1:0][DW-1:0]    tdata;
    logic [N-1:0][IW-1:0]    tid;
    logic [N-1:0][DESTW-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_INPUTS AXI-Stream sources share one
// sink. A grant is held until the source's tlast beat transfers, so packets
// never interleave. The output is a single register stage.
module axis_rr_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int IDX_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_rr_arbiter_if.slave       s_axis,
    axis_rr_arbiter_if.master      m_axis,
    output logic                   locked,
    output logic [IDX_WIDTH-1:0]   grant_idx,
    output logic [COUNT_WIDTH-1:0] pkt_count
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic                   vld_q, vld_d;
    logic                   last_q, last_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [TID_WIDTH-1:0]   id_q, id_d;
    logic [TDEST_WIDTH-1:0] dest_q, dest_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                   out_ready;
    logic [IDX_WIDTH-1:0]   sel;
    logic                   sel_ok;
    logic [NUM_INPUTS-1:0]  s_rdy;
    logic                   xfer;

    assign out_ready = !vld_q || m_axis.tready[0];

    // Source selection: the held grant while locked, else the first valid
    // source scanning upward from ptr+1 with wrap.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        sel    = grant_q;
        sel_ok = 1'b0;
        cand   = '0;
        if (state_q == LOCKED) begin
            sel_ok = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_INPUTS; k++) begin
                cand = IDX_WIDTH'((int'(ptr_q) + k) % NUM_INPUTS);
                if (!sel_ok && s_axis.tvalid[cand]) begin
                    sel    = cand;
                    sel_ok = 1'b1;
                end
            end
        end
    end

    // Only the selected source sees ready; nobody does while in reset.
    always_comb begin
        s_rdy = '0;
        if (!rst && out_ready && sel_ok) s_rdy[sel] = 1'b1;
    end

    assign s_axis.tready = s_rdy;
    assign xfer          = s_axis.tvalid[sel] && s_rdy[sel];

    // Next state: output load/drain, lock tracking, packet counting.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        vld_d   = vld_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            vld_d  = 1'b1;
            last_d = s_axis.tlast[sel];
            data_d = s_axis.tdata[sel];
            id_d   = s_axis.tid[sel];
            dest_d = s_axis.tdest[sel];
            if (state_q == UNLOCKED) begin
                ptr_d   = sel;
                grant_d = sel;
                if (!s_axis.tlast[sel]) state_d = LOCKED;
            end else if (s_axis.tlast[sel]) begin
                state_d = UNLOCKED;
            end
        end else if (vld_q && m_axis.tready[0]) begin
            vld_d = 1'b0;
        end
        if (vld_q && m_axis.tready[0] && last_q) cnt_d = cnt_q + 1'b1;
    end

    // State registers; ptr resets to the top index so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
            ptr_q   <= IDX_WIDTH'(NUM_INPUTS - 1);
            grant_q <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis.tvalid[0] = vld_q;
    assign m_axis.tlast[0]  = last_q;
    assign m_axis.tdata[0]  = data_q;
    assign m_axis.tid[0]    = id_q;
    assign m_axis.tdest[0]  = dest_q;
    assign locked           = (state_q == LOCKED);
    assign grant_idx        = grant_q;
    assign pkt_count        = cnt_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: single beats, round robin, locking,
// backpressure, mid-packet reset and a stalled locked source.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        locked;
    logic [1:0]  grant_idx;
    logic [31:0] pkt_count;
    int          checks = 0;
    int          errors = 0;

    axis_rr_arbiter_if #(.N(N), .DW(DW), .IW(2), .DESTW(2)) s_if ();
    axis_rr_arbiter_if #(.N(1), .DW(DW), .IW(2), .DESTW(2)) m_if ();

    axis_rr_arbiter #(
        .NUM_INPUTS(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(2), .TID_WIDTH(2), .COUNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
        .locked(locked), .grant_idx(grant_idx), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
        s_if.tvalid[src] = v;
        s_if.tdata[src]  = d;
        s_if.tlast[src]  = l;
        s_if.tid[src]    = 2'(src);
        s_if.tdest[src]  = 2'(3 - src);
    endtask

    task automatic do_reset();
        s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0; s_if.tid = '0; s_if.tdest = '0;
        m_if.tready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0; s_if.tid = '0; s_if.tdest = '0;
        m_if.tready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        checks++; if (m_if.tvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0h exp 0", m_if.tvalid[0]); end
        checks++; if (m_if.tdata[0] !== 32'h0) begin errors++; $display("FAIL rst_tdata got %0h exp 0", m_if.tdata[0]); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0h exp 0", locked); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant got %0h exp 0", grant_idx); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0h exp 0", pkt_count); end
        drive(1, 1'b1, 32'h1, 1'b1);
        #1;
        checks++; if (s_if.tready !== 4'b0000) begin errors++; $display("FAIL rst_tready got %b exp 0000", s_if.tready); end
        drive(1, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 1'b1, 32'h5, 1'b1);
        #1;
        checks++; if (s_if.tready !== 4'b0001) begin errors++; $display("FAIL single_tready got %b exp 0001", s_if.tready); end
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h5) begin errors++; $display("FAIL single_out got v=%0h d=%0h exp v=1 d=5", m_if.tvalid[0], m_if.tdata[0]); end
        checks++; if (locked !== 1'b0 || pkt_count !== 32'd0) begin errors++; $display("FAIL single_mid got lk=%0h cnt=%0d exp lk=0 cnt=0", locked, pkt_count); end
        tick();
        checks++; if (m_if.tvalid[0] !== 1'b0 || pkt_count !== 32'd1 || locked !== 1'b0) begin errors++; $display("FAIL single_done got v=%0h cnt=%0d lk=%0h exp v=0 cnt=1 lk=0", m_if.tvalid[0], pkt_count, locked); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 32'h10 + 32'(i), 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h10 + 32'(k % 4) || grant_idx !== 2'(k % 4) || m_if.tid[0] !== 2'(k % 4) || m_if.tdest[0] !== 2'(3 - k % 4)) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%0h d=%0h g=%0d id=%0d dst=%0d exp v=1 d=%0h g=%0d", k, m_if.tvalid[0], m_if.tdata[0], grant_idx, m_if.tid[0], m_if.tdest[0], 32'h10 + 32'(k % 4), k % 4);
            end
        end
        s_if.tvalid = '0;
        tick();
        checks++; if (m_if.tvalid[0] !== 1'b0 || pkt_count !== 32'd8) begin errors++; $display("FAIL rr_count got v=%0h cnt=%0d exp v=0 cnt=8", m_if.tvalid[0], pkt_count); end
    endtask

    task automatic test_locked();
        do_reset();
        drive(2, 1'b1, 32'h30, 1'b1);
        for (int j = 0; j < 4; j++) begin
            drive(1, 1'b1, 32'h21 + 32'(j), j == 3);
            #1;
            checks++; if (s_if.tready !== 4'b0010) begin errors++; $display("FAIL lock_tready%0d got %b exp 0010", j, s_if.tready); end
            tick();
            checks++;
            if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h21 + 32'(j) || locked !== (j != 3) || grant_idx !== 2'd1) begin
                errors++;
                $display("FAIL lock_beat%0d got v=%0h d=%0h lk=%0h g=%0d exp v=1 d=%0h lk=%0d g=1", j, m_if.tvalid[0], m_if.tdata[0], locked, grant_idx, 32'h21 + 32'(j), j != 3);
            end
        end
        drive(1, 1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (s_if.tready !== 4'b0100) begin errors++; $display("FAIL lock_next_tready got %b exp 0100", s_if.tready); end
        tick();
        drive(2, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h30 || grant_idx !== 2'd2) begin errors++; $display("FAIL lock_nobubble got v=%0h d=%0h g=%0d exp v=1 d=30 g=2", m_if.tvalid[0], m_if.tdata[0], grant_idx); end
        tick();
        checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL lock_count got %0d exp 2", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(0, 1'b1, 32'h41, 1'b0);
        tick();
        drive(0, 1'b1, 32'h42, 1'b0);
        m_if.tready = 1'b0;
        #1;
        checks++; if (s_if.tready !== 4'b0000) begin errors++; $display("FAIL bp_tready got %b exp 0000", s_if.tready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h41 || s_if.tready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%0h d=%0h rdy=%b exp v=1 d=41 rdy=0000", c, m_if.tvalid[0], m_if.tdata[0], s_if.tready);
            end
        end
        m_if.tready = 1'b1;
        #1;
        checks++; if (s_if.tready !== 4'b0001) begin errors++; $display("FAIL bp_resume_tready got %b exp 0001", s_if.tready); end
        tick();
        checks++; if (m_if.tvalid[0] !== 1'b1 || m_if.tdata[0] !== 32'h42) begin errors++; $display("FAIL bp_beat1 got v=%0h d=%0h exp v=1 d=42", m_if.tvalid[0], m_if.tdata[0]); end
        drive(0, 1'b1, 32'h43, 1'b1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tdata[0] !== 32'h43 || m_if.tlast[0] !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL bp_beat2 got d=%0h l=%0h lk=%0h exp d=43 l=1 lk=0", m_if.tdata[0], m_if.tlast[0], locked); end
        tick();
        checks++; if (m_if.tvalid[0] !== 1'b0 || pkt_count !== 32'd1) begin errors++; $display("FAIL bp_count got v=%0h cnt=%0d exp v=0 cnt=1", m_if.tvalid[0], pkt_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2, 1'b1, 32'h51, 1'b0);
        tick();
        drive(2, 1'b1, 32'h52, 1'b0);
        tick();
        checks++; if (locked !== 1'b1 || grant_idx !== 2'd2 || m_if.tdata[0] !== 32'h52) begin errors++; $display("FAIL rm_pre got lk=%0h g=%0d d=%0h exp lk=1 g=2 d=52", locked, grant_idx, m_if.tdata[0]); end
        drive(2, 1'b1, 32'h53, 1'b1);
        drive(0, 1'b1, 32'h60, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (m_if.tvalid[0] !== 1'b0 || m_if.tdata[0] !== 32'h0 || locked !== 1'b0 || grant_idx !== 2'd0 || s_if.tready !== 4'b0000) begin
            errors++;
            $display("FAIL rm_async got v=%0h d=%0h lk=%0h g=%0d rdy=%b exp all zero", m_if.tvalid[0], m_if.tdata[0], locked, grant_idx, s_if.tready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (s_if.tready !== 4'b0001) begin errors++; $display("FAIL rm_first_tready got %b exp 0001", s_if.tready); end
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(2, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tdata[0] !== 32'h60 || grant_idx !== 2'd0 || locked !== 1'b0) begin errors++; $display("FAIL rm_first got d=%0h g=%0d lk=%0h exp d=60 g=0 lk=0", m_if.tdata[0], grant_idx, locked); end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        drive(3, 1'b1, 32'h71, 1'b0);
        #1;
        checks++; if (s_if.tready !== 4'b1000) begin errors++; $display("FAIL st_tready got %b exp 1000", s_if.tready); end
        tick();
        checks++; if (locked !== 1'b1 || grant_idx !== 2'd3 || m_if.tdata[0] !== 32'h71) begin errors++; $display("FAIL st_lock got lk=%0h g=%0d d=%0h exp lk=1 g=3 d=71", locked, grant_idx, m_if.tdata[0]); end
        drive(3, 1'b0, 32'h72, 1'b0);
        drive(0, 1'b1, 32'h80, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (m_if.tvalid[0] !== 1'b0 || locked !== 1'b1 || s_if.tready !== 4'b1000) begin
                errors++;
                $display("FAIL st_idle%0d got v=%0h lk=%0h rdy=%b exp v=0 lk=1 rdy=1000", c, m_if.tvalid[0], locked, s_if.tready);
            end
        end
        drive(3, 1'b1, 32'h72, 1'b0);
        tick();
        checks++; if (m_if.tdata[0] !== 32'h72 || m_if.tvalid[0] !== 1'b1) begin errors++; $display("FAIL st_beat1 got v=%0h d=%0h exp v=1 d=72", m_if.tvalid[0], m_if.tdata[0]); end
        drive(3, 1'b1, 32'h73, 1'b1);
        tick();
        drive(3, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tdata[0] !== 32'h73 || locked !== 1'b0 || s_if.tready !== 4'b0001) begin errors++; $display("FAIL st_beat2 got d=%0h lk=%0h rdy=%b exp d=73 lk=0 rdy=0001", m_if.tdata[0], locked, s_if.tready); end
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        checks++; if (m_if.tdata[0] !== 32'h80 || grant_idx !== 2'd0) begin errors++; $display("FAIL st_src0 got d=%0h g=%0d exp d=80 g=0", m_if.tdata[0], grant_idx); end
        tick();
        checks++; if (pkt_count !== 32'd2 || m_if.tvalid[0] !== 1'b0) begin errors++; $display("FAIL st_count got cnt=%0d v=%0h exp cnt=2 v=0", pkt_count, m_if.tvalid[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_locked();
        test_backpressure();
        test_reset_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream sink (a checker or a NoC injection port) among NUM_INPUTS traffic sources in the test harness. The arbiter grants one source at a time and holds the grant until that source's tlast beat transfers, so packets are never interleaved. The output is a single registered stage, which cuts the combinational path from the sources to the sink.

## Interface
Parameters:
- NUM_INPUTS, 4, number of source ports; must be 2 or more.
- TDATA_WIDTH, 512, data width.
- TDEST_WIDTH, 2, tdest width.
- TID_WIDTH, 2, tid width.
- COUNT_WIDTH, 32, width of the output packet counter.
- IDX_WIDTH, $clog2(NUM_INPUTS), width of the port index (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tvalid  in  [NUM_INPUTS]  per-source valid.
- s_axis_tready  out  [NUM_INPUTS]  per-source ready.
- s_axis_tdata  in  [NUM_INPUTS][TDATA_WIDTH]  per-source data.
- s_axis_tlast  in  [NUM_INPUTS]  per-source last.
- s_axis_tid  in  [NUM_INPUTS][TID_WIDTH]  per-source id.
- s_axis_tdest  in  [NUM_INPUTS][TDEST_WIDTH]  per-source dest.
- m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest  out  1/TDATA_WIDTH/1/TID_WIDTH/TDEST_WIDTH  registered output beat.
- m_axis_tready  in  1  sink ready.
- locked  out  1  a multi-beat packet is in progress.
- grant_idx  out  IDX_WIDTH  source that currently holds the lock, or the source that was last granted.
- pkt_count  out  COUNT_WIDTH  number of tlast beats accepted by the sink.

## Operation
- Output stage: one register. out_ready = !m_axis_tvalid || m_axis_tready.
- States:
  - UNLOCKED. The selected source is the first source with tvalid set, scanning upward from ptr+1 modulo NUM_INPUTS.
  - LOCKED. The selected source is grant_idx, regardless of the tvalid pattern on other sources.
- s_axis_tready[i] = out_ready && (i == selected). All other sources see tready=0. The path from m_axis_tready to s_axis_tready is combinational.
- Input transfer: a beat transfers when s_axis_tvalid[selected] && s_axis_tready[selected]. The beat's tdata, tlast, tid and tdest are loaded into the output register and m_axis_tvalid is set to 1.
- A transfer in UNLOCKED state:
  - Sets ptr and grant_idx to the selected source.
  - With tlast=0, moves to LOCKED.
  - With tlast=1 (single-beat packet), stays UNLOCKED.
- A transfer in LOCKED state with tlast=1 moves to UNLOCKED. ptr is unchanged, so arbitration resumes after the source that just finished.
- If m_axis_tvalid && m_axis_tready and no new input beat transfers, m_axis_tvalid is cleared to 0.
- pkt_count increments by 1 on each output handshake with m_axis_tlast=1. It wraps modulo 2^COUNT_WIDTH.
- Payload fields pass through unmodified. tid is not rewritten.
- A LOCKED source that drops tvalid stalls the output. The lock is not released until that source's tlast transfers. There is no timeout.

## Timing
- Latency: an input beat appears on m_axis one cycle after it transfers.
- Throughput: 1 beat per cycle while the sink holds m_axis_tready=1. This includes back-to-back packets from different sources: arbitration happens in the same cycle as the transfer, with no idle cycle between packets.
- Reset values: m_axis_tvalid=0, m_axis_tdata/tlast/tid/tdest=0, locked=0, grant_idx=0, ptr=NUM_INPUTS-1 (so source 0 wins first), pkt_count=0.
- Reset asserted mid-packet:
  - Any pending output beat is discarded.
  - The lock is cleared.
  - s_axis_tready is all-zero while rst=1.
- Simultaneous events:
  - Output drain and input load in the same cycle: the register is overwritten with the new beat and m_axis_tvalid stays 1.
  - A tlast input transfer and another source's request in the same cycle: the other source can only be granted in the next cycle.
- m_axis_tvalid never falls without a handshake. Output data is stable while m_axis_tvalid && !m_axis_tready.
- ptr wrap: from NUM_INPUTS-1 the scan continues at index 0.

## Test plan
- Reset, then source 0 sends a single-beat packet (tdata=0x5, tlast=1) with m_axis_tready=1:
  - m_axis_tvalid=1 with tdata=0x5 one cycle after the transfer.
  - pkt_count=1 after the output handshake.
  - locked stays 0 throughout.
- Sources 0–3 all continuously send single-beat packets with m_axis_tready=1:
  - Grant order is 0,1,2,3,0,…, one beat per cycle.
  - pkt_count=8 after 8 output handshakes.
- Source 1 sends a 4-beat packet while source 2 is valid throughout:
  - Output carries 4 consecutive beats from source 1, then source 2's beat with no bubble.
  - s_axis_tready[2]=0 until the cycle that source 1's tlast transfers.
  - locked is 1 from after source 1's first beat until after its tlast beat.
- m_axis_tready held at 0 for 5 cycles mid-packet:
  - Output beat stays stable and m_axis_tvalid stays 1.
  - All s_axis_tready=0.
  - The stream resumes with no lost or duplicated beats.
- rst pulsed during beat 2 of a 3-beat packet:
  - Outputs return to reset values immediately (asynchronously).
  - After release, source 0 wins first.
- Locked source 3 deasserts tvalid for 3 cycles while source 0 is valid:
  - Output idles for those 3 cycles.
  - Source 0 is granted only after source 3's tlast transfers.
